// File: rtl/jtlabrun_romslot.sv
// Single-client SDRAM read slot with a 2-entry word cache.
// It converts the client cs/addr/ok handshake into sdram_req/ack/data_rdy transactions.
module jtlabrun_romslot #(
  parameter int unsigned AW     = 17,
  parameter int unsigned DW     = 8,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          slot_cs,
  input  logic [AW-1:0] slot_addr,
  output logic          slot_ok,
  output logic [DW-1:0] slot_dout,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_dst,
  input  logic          data_rdy,
  output logic [21:0]   sdram_addr,
  input  logic [15:0]   data_read
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state_q;
  logic [AW-1:0] tag_q [2];
  logic [15:0]   data_q [2];
  logic [1:0]    valid_q;
  logic          lru_q;
  logic [AW-1:0] req_waddr_q;

  logic [AW-1:0] waddr;
  logic [1:0]    hit_way;
  logic          hit;
  logic [15:0]   hit_word;
  logic [DW-1:0] dout_d;
  logic          unused_dst;

  assign unused_dst = data_dst;

  if (DW == 16) begin : g_w16
    assign waddr  = slot_addr;
    assign dout_d = hit_word;
  end else begin : g_w8
    assign waddr  = slot_addr >> 1;
    assign dout_d = slot_addr[0] ? hit_word[15:8] : hit_word[7:0];
  end

  always_comb begin
    hit_way[0] = valid_q[0] && (tag_q[0] == waddr);
    hit_way[1] = valid_q[1] && (tag_q[1] == waddr);
    hit        = |hit_way;
    hit_word   = hit_way[1] ? data_q[1] : data_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst || downloading) begin
      state_q     <= IDLE;
      slot_ok     <= 1'b0;
      slot_dout   <= '0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      valid_q     <= '0;
      lru_q       <= 1'b0;
      req_waddr_q <= '0;
    end else begin
      // Hit path runs regardless of FSM state; a fill in the same cycle owns the LRU update.
      slot_ok <= slot_cs && hit;
      if (slot_cs && hit) begin
        slot_dout <= dout_d;
        lru_q     <= ~hit_way[1];
      end
      case (state_q)
        IDLE: begin
          if (slot_cs && !hit) begin
            req_waddr_q <= waddr;
            sdram_addr  <= OFFSET + 22'(waddr);
            sdram_req   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (data_rdy) begin
            valid_q[lru_q] <= 1'b1;
            tag_q[lru_q]   <= req_waddr_q;
            data_q[lru_q]  <= data_read;
            lru_q          <= ~lru_q;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtlabrun_romslot.sv
// Directed bench for jtlabrun_romslot: word/byte modes, LRU replacement, download abort, offset wrap.
module tb_jtlabrun_romslot;

  logic        clk = 1'b0;
  logic        rst, downloading;
  logic [15:0] data_read;

  always #5 clk = ~clk;

  // 16-bit client, OFFSET 0x10000
  logic        cs16, ack16, rdy16, ok16, req16;
  logic [16:0] a16;
  logic [15:0] dout16;
  logic [21:0] sa16;
  // 8-bit client, OFFSET 0
  logic        cs8, ack8, rdy8, ok8, req8;
  logic [16:0] a8;
  logic [7:0]  dout8;
  logic [21:0] sa8;
  // 16-bit client, wrapping OFFSET
  logic        csw, ackw, rdyw, okw, reqw;
  logic [16:0] aw;
  logic [15:0] doutw;
  logic [21:0] saw;

  jtlabrun_romslot #(.AW(17), .DW(16), .OFFSET(22'h10000)) u_d16 (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs16), .slot_addr(a16),
    .slot_ok(ok16), .slot_dout(dout16), .sdram_req(req16), .sdram_ack(ack16),
    .data_dst(1'b0), .data_rdy(rdy16), .sdram_addr(sa16), .data_read(data_read));

  jtlabrun_romslot #(.AW(17), .DW(8), .OFFSET(22'h0)) u_d8 (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs8), .slot_addr(a8),
    .slot_ok(ok8), .slot_dout(dout8), .sdram_req(req8), .sdram_ack(ack8),
    .data_dst(1'b0), .data_rdy(rdy8), .sdram_addr(sa8), .data_read(data_read));

  jtlabrun_romslot #(.AW(17), .DW(16), .OFFSET(22'h3FFFFF)) u_dw (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(csw), .slot_addr(aw),
    .slot_ok(okw), .slot_dout(doutw), .sdram_req(reqw), .sdram_ack(ackw),
    .data_dst(1'b0), .data_rdy(rdyw), .sdram_addr(saw), .data_read(data_read));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Miss on addr, ack after one cycle, data one cycle later, then expect the hit.
  task automatic fill8(input logic [16:0] addr, input logic [21:0] exp_sa,
                       input logic [15:0] data, input logic [7:0] exp_byte);
    cs8 = 1'b1;
    a8  = addr;
    tick();
    check("fill8_req", 32'(req8), 32'd1);
    check("fill8_sa", 32'(sa8), 32'(exp_sa));
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    check("fill8_req_drop", 32'(req8), 32'd0);
    tick();
    rdy8 = 1'b1;
    data_read = data;
    tick();
    rdy8 = 1'b0;
    check("fill8_ok_lat", 32'(ok8), 32'd0);
    tick();
    check("fill8_ok", 32'(ok8), 32'd1);
    check("fill8_dout", 32'(dout8), 32'(exp_byte));
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; data_read = '0;
    cs16 = 0; ack16 = 0; rdy16 = 0; a16 = '0;
    cs8 = 0;  ack8 = 0;  rdy8 = 0;  a8 = '0;
    csw = 0;  ackw = 0;  rdyw = 0;  aw = '0;
    tick();
    tick();
    check("rst_ok", 32'(ok8), 32'd0);
    check("rst_dout", 32'(dout8), 32'd0);
    check("rst_req", 32'(req16), 32'd0);
    check("rst_sa", 32'(sa16), 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss, DW=16
    cs16 = 1'b1;
    a16  = 17'h00005;
    tick();
    check("cold_req", 32'(req16), 32'd1);
    check("cold_sa", 32'(sa16), 32'h10005);
    check("cold_ok0", 32'(ok16), 32'd0);
    tick();
    tick();
    check("cold_req_hold", 32'(req16), 32'd1);
    ack16 = 1'b1;
    tick();
    ack16 = 1'b0;
    check("cold_req_drop", 32'(req16), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("cold_ok_wait", 32'(ok16), 32'd0);
    rdy16 = 1'b1;
    data_read = 16'hBEEF;
    tick();
    rdy16 = 1'b0;
    check("cold_ok_lat", 32'(ok16), 32'd0);
    tick();
    check("cold_ok", 32'(ok16), 32'd1);
    check("cold_dout", 32'(dout16), 32'hBEEF);
    cs16 = 1'b0;
    tick();
    check("cold_cs_off", 32'(ok16), 32'd0);

    // Hit path and byte select, DW=8
    fill8(17'h6, 22'h3, 16'h12AB, 8'hAB);
    a8 = 17'h7;
    tick();
    check("hit_hi_ok", 32'(ok8), 32'd1);
    check("hit_hi_dout", 32'(dout8), 32'h12);
    check("hit_hi_noreq", 32'(req8), 32'd0);
    a8 = 17'h6;
    tick();
    check("hit_lo_dout", 32'(dout8), 32'hAB);

    // LRU: A, B, touch A, C replaces B
    fill8(17'h20, 22'h10, 16'hA1A0, 8'hA0);
    fill8(17'h22, 22'h11, 16'hB1B0, 8'hB0);
    a8 = 17'h21;
    tick();
    check("lru_touchA", 32'(dout8), 32'hA1);
    fill8(17'h24, 22'h12, 16'hC1C0, 8'hC0);
    a8 = 17'h20;
    tick();
    check("lru_A_ok", 32'(ok8), 32'd1);
    check("lru_A_dout", 32'(dout8), 32'hA0);
    check("lru_A_noreq", 32'(req8), 32'd0);
    a8 = 17'h22;
    tick();
    check("lru_B_miss", 32'(ok8), 32'd0);
    check("lru_B_req", 32'(req8), 32'd1);
    check("lru_B_sa", 32'(sa8), 32'h11);

    // Abort on download after ack
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    downloading = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rdy8 = (i == 2);
      data_read = 16'hDEAD;
      tick();
      check("dl_req", 32'(req8), 32'd0);
      check("dl_ok", 32'(ok8), 32'd0);
    end
    rdy8 = 1'b0;
    downloading = 1'b0;
    tick();
    check("dl_fresh_req", 32'(req8), 32'd1);
    check("dl_fresh_sa", 32'(sa8), 32'h11);
    check("dl_fresh_ok", 32'(ok8), 32'd0);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    tick();
    rdy8 = 1'b1;
    data_read = 16'hB1B0;
    tick();
    rdy8 = 1'b0;
    tick();
    check("dl_refill_ok", 32'(ok8), 32'd1);
    check("dl_refill_dout", 32'(dout8), 32'hB0);

    // Address change during a fetch
    a8 = 17'h20;
    tick();
    check("chg_req1", 32'(req8), 32'd1);
    check("chg_sa1", 32'(sa8), 32'h10);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    a8 = 17'h40;
    tick();
    rdy8 = 1'b1;
    data_read = 16'h5A20;
    tick();
    rdy8 = 1'b0;
    check("chg_ok_a", 32'(ok8), 32'd0);
    tick();
    check("chg_ok_b", 32'(ok8), 32'd0);
    check("chg_req2", 32'(req8), 32'd1);
    check("chg_sa2", 32'(sa8), 32'h20);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    check("chg_ok_c", 32'(ok8), 32'd0);
    rdy8 = 1'b1;
    data_read = 16'h7741;
    tick();
    rdy8 = 1'b0;
    check("chg_ok_d", 32'(ok8), 32'd0);
    tick();
    check("chg_ok", 32'(ok8), 32'd1);
    check("chg_dout", 32'(dout8), 32'h41);
    a8 = 17'h20;
    tick();
    check("chg_old_ok", 32'(ok8), 32'd1);
    check("chg_old_dout", 32'(dout8), 32'h20);
    check("chg_old_noreq", 32'(req8), 32'd0);
    cs8 = 1'b0;

    // Offset wrap
    csw = 1'b1;
    aw  = 17'h2;
    tick();
    check("wrap_req", 32'(reqw), 32'd1);
    check("wrap_sa", 32'(saw), 32'h000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtlabrun_romslot.md
Name: jtlabrun_romslot

Overview:
- Single-client SDRAM read slot with a 2-entry word cache.
- Sits between one ROM client of the Labyrinth Runner game top (main CPU ROM or GFX ROM fetch) and the SDRAM read port.
- Turns the client's cs/addr/ok protocol into sdram_req/ack/data_rdy transactions at a fixed word offset.
- Serves repeated accesses to recently fetched words without touching SDRAM.

Parameters:
AW, 17, client address width in client-data units
DW, 8, client data width; only 8 or 16 are legal
OFFSET, 22'h0, SDRAM word offset added to the client word address

Ports:
clk  input  1  system clock (SDRAM domain)
rst  input  1  synchronous active-high reset
downloading  input  1  ROM download in progress; flushes the slot
slot_cs  input  1  client requests data at slot_addr
slot_addr  input  AW  client address
slot_ok  output  1  slot_dout valid for slot_addr
slot_dout  output  DW  read data
sdram_req  output  1  read request to SDRAM controller
sdram_ack  input  1  controller accepted the request
data_dst  input  1  data strobe from controller; not used for capture
data_rdy  input  1  data_read valid for the accepted request
sdram_addr  output  22  SDRAM word address
data_read  input  16  SDRAM read data

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset values (also applied while downloading=1): slot_ok=0, slot_dout=0, sdram_req=0, sdram_addr=0, both cache entries invalid, LRU pointer=0, FSM=IDLE.
- Word address:
  - DW=16: waddr = slot_addr.
  - DW=8: waddr = slot_addr>>1.
  - sdram_addr = OFFSET + waddr, truncated to 22 bits; wrap-around is allowed.
- Byte select (DW=8): slot_dout = slot_addr[0] ? word[15:8] : word[7:0]. For DW=16 the whole word is output.
- Cache: 2 entries, each holding valid, tag (full waddr), and 16-bit data.
  - Hit = valid && tag==waddr on either entry.
  - LRU pointer names the entry to replace. On a hit it is set to the other entry; on a fill it is set to the other entry.
- Client timing:
  - slot_ok and slot_dout are registered.
  - If at cycle N slot_cs=1 and the lookup hits, then at N+1 slot_ok=1 and slot_dout = data for the cycle-N address.
  - slot_cs=0 or a miss at N gives slot_ok=0 at N+1.
  - The client must hold slot_addr until it sees slot_ok.
  - Hit-to-ok latency is 1 cycle. A miss takes SDRAM latency + 2 cycles.
- FSM:
  - IDLE: on slot_cs && miss, latch waddr and byte select, drive sdram_addr, set sdram_req=1, go to REQ.
  - REQ: hold sdram_req and sdram_addr until sdram_ack=1. In the ack cycle, deassert sdram_req next cycle and go to WAIT.
  - WAIT: on data_rdy=1, write data_read into the LRU entry (valid=1, tag=latched waddr), flip LRU, go to IDLE. The refilled word hits on the next lookup.
- Simultaneous events and boundary cases:
  - data_rdy during REQ (before ack) is ignored.
  - A slot_cs drop or address change during REQ/WAIT does not abort the transaction. The fill completes into the cache; the new address is looked up from IDLE afterwards.
  - A lookup that hits while FSM≠IDLE is still served (hit path independent of FSM).
  - A miss while busy waits for IDLE.
  - Same-word fill and hit: a fill never creates a duplicate tag, because the FSM only starts on a miss.
  - downloading=1 or rst mid-transaction: drop sdram_req in the next cycle, abandon the transaction, and ignore any later data_rdy. The FSM leaves IDLE only after downloading returns to 0.
- No more than one outstanding SDRAM request at any time.

Test Plan:
- Cold miss, DW=16, OFFSET=22'h10000: cs=1, addr=17'h00005.
  - sdram_req rises with sdram_addr=22'h10005.
  - Ack after 3 cycles; data_rdy with 16'hBEEF 4 cycles later.
  - slot_ok=1 with dout=16'hBEEF 2 cycles after data_rdy.
- Hit path, DW=8, OFFSET=0: fill word 3 with 16'h12AB via addr=17'h6.
  - Then addr=17'h7 gives ok in 1 cycle with dout=8'h12 and no sdram_req.
  - Then addr=17'h6 gives dout=8'hAB.
- LRU replacement: fill words A, B, touch A, then miss on C.
  - C replaces B.
  - Re-read A hits with no sdram_req; re-read B misses.
- Abort on download: miss issued and acked, then downloading=1 for 5 cycles.
  - sdram_req=0 and slot_ok=0 throughout.
  - A data_rdy during downloading is not cached.
  - After downloading drops, the same addr issues a fresh sdram_req.
- Address change mid-fetch: miss on addr 17'h20, then addr changes to 17'h40 before data_rdy.
  - The fill for 17'h20 completes.
  - A second sdram_req for 17'h40 follows in IDLE; ok asserts only for 17'h40 data.
- Offset wrap: OFFSET=22'h3FFFFF, DW=16, addr=17'h2 gives sdram_addr=22'h000001.
